pipe_stage_reg: RTL

- Generalised pipeline-stage register for the RV32I pipeline, replacing the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one parametrised block.
- Carries an opaque payload of WIDTH bits (ctrl_t plus datapath fields, packed by the instantiating stage).
- Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush for branch/trap squash, and performance counters for stalls and squashed instructions.

---
 rtl/pipe_stage_reg.sv | 99 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready pipeline register with optional skid entry,
// synchronous flush and saturating stall/squash counters.
module pipe_stage_reg #(
    parameter int WIDTH          = 32,
    parameter bit SKID           = 1'b1,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d, skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d, squash_q, squash_d;
    logic               in_fire, out_fire;
    logic [1:0]         squash_inc;
    logic [CNT_W+1:0]   stall_sum, squash_sum;

    assign out_valid  = state_q != EMPTY;
    assign out_data   = main_q;
    assign occupancy  = state_q;
    assign stall_cnt  = stall_q;
    assign squash_cnt = squash_q;

    // With the skid entry, in_ready is a pure function of state so out_ready never reaches it.
    assign in_ready = reset & (SKID ? (state_q != FULL) : (state_q == EMPTY || out_ready));
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
                ONE: if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire && SKID) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
                FULL: if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // An entry leaving downstream in the flush cycle was delivered, not squashed.
    assign squash_inc = flush ? (state_q - {1'b0, out_fire}) : 2'd0;
    assign stall_sum  = {2'b00, stall_q} + {{(CNT_W+1){1'b0}}, out_valid & ~out_ready};
    assign squash_sum = {2'b00, squash_q} + {{CNT_W{1'b0}}, squash_inc};
    assign stall_d    = |stall_sum[CNT_W+1:CNT_W] ? '1 : stall_sum[CNT_W-1:0];
    assign squash_d   = |squash_sum[CNT_W+1:CNT_W] ? '1 : squash_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            stall_q  <= '0;
            squash_q <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            stall_q  <= stall_d;
            squash_q <= squash_d;
        end
    end

endmodule
